dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core's memory stage. It accepts word-aligned load/store requests with per-byte write enables, already lane-positioned by the store path, from the core's memory interface. Stores are committed on acceptance. Loads return a full 32-bit word after a configurable number of wait states, and the core's load path extracts bytes and halfwords.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bus between the MIPS core (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_addr/req_we/req_wdata must be stable while req_valid is high. The
  // response is a single-cycle rsp_valid pulse with no back-pressure;
  // rsp_rdata/rsp_err hold until the next response is captured.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled stores commit on accept, loads return a
// full word after WAIT_CYC wait states. Define DMEM_ERRCHK_EN for error checks.
module dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                rerr_q, rerr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   req_idx;
  logic                accept;
  logic                is_store;
  logic                req_err;
  logic                wr_en;

  assign req_idx  = bus.req_addr[ADDR_W+1:2];
  assign accept   = bus.req_valid && bus.req_ready;
  assign is_store = |bus.req_we;

  // Ready is combinational so the first edge after reset release can accept.
  assign bus.req_ready = rst && (state_q != S_WAIT);

`ifdef DMEM_ERRCHK_EN
  logic addr_bad;
  logic we_bad;

  always_comb begin
    addr_bad = |bus.req_addr[31:ADDR_W+2];
    case (bus.req_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: we_bad = 1'b0;
      default:                   we_bad = 1'b1;
    endcase
    req_err = addr_bad || we_bad;
  end

  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = bus.req_addr[1:0];
`else
  assign req_err = 1'b0;

  // Upper address bits are dropped, so the array wraps.
  logic [31-ADDR_W:0] unused_addr;
  assign unused_addr = {bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
`endif

  assign wr_en = accept && is_store && !req_err;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_we[i]) begin
          mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    raddr_d     = raddr_q;
    rerr_d      = rerr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rerr_q ? 32'd0 : mem[raddr_q];
          rsp_err_d   = rerr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        // IDLE and RESP accept identically; RESP without a request drops to IDLE.
        if (accept) begin
          if (is_store) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = req_err;
          end else if (WAIT_CYC == 0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_err ? 32'd0 : mem[req_idx];
            rsp_err_d   = req_err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
            raddr_d = req_idx;
            rerr_d  = req_err;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      raddr_q     <= '0;
      rerr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      rerr_q      <= rerr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYC 0, 1, 3) checked
// against a word-array reference model with byte-lane merge rules.
module tb_dmem_responder;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUTs ----------------
  logic [2:0]  vld;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [1:0]  dbg0, dbg1, dbg3;

  dmem_responder_if bus_w0();
  dmem_responder_if bus_w1();
  dmem_responder_if bus_w3();

  assign bus_w0.req_valid = vld[0];
  assign bus_w0.req_addr  = addr;
  assign bus_w0.req_we    = we;
  assign bus_w0.req_wdata = wdata;
  assign bus_w1.req_valid = vld[1];
  assign bus_w1.req_addr  = addr;
  assign bus_w1.req_we    = we;
  assign bus_w1.req_wdata = wdata;
  assign bus_w3.req_valid = vld[2];
  assign bus_w3.req_addr  = addr;
  assign bus_w3.req_we    = we;
  assign bus_w3.req_wdata = wdata;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dut_w0 (.clk(clk), .rst(rst), .bus(bus_w0.slave), .dbg_state(dbg0));
  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(1)) dut_w1 (.clk(clk), .rst(rst), .bus(bus_w1.slave), .dbg_state(dbg1));
  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(3)) dut_w3 (.clk(clk), .rst(rst), .bus(bus_w3.slave), .dbg_state(dbg3));

  int          sel;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  always_comb begin
    case (sel)
      0: begin
        o_ready = bus_w0.req_ready; o_valid = bus_w0.rsp_valid;
        o_err   = bus_w0.rsp_err;   o_rdata = bus_w0.rsp_rdata;
      end
      1: begin
        o_ready = bus_w1.req_ready; o_valid = bus_w1.rsp_valid;
        o_err   = bus_w1.rsp_err;   o_rdata = bus_w1.rsp_rdata;
      end
      default: begin
        o_ready = bus_w3.req_ready; o_valid = bus_w3.rsp_valid;
        o_err   = bus_w3.rsp_err;   o_rdata = bus_w3.rsp_rdata;
      end
    endcase
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [3][1024];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic exp_err(input logic [31:0] a, input logic [3:0] w);
`ifdef DMEM_ERRCHK_EN
    logic bad_we;
    bad_we = (w != 4'b0000) &&
             !(w inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    return (a[31:AW+2] != '0) || bad_we;
`else
    logic [35:0] unused_args;
    unused_args = {a, w};
    return 1'b0;
`endif
  endfunction

  task automatic model_store(input int k, input logic [31:0] a, input logic [3:0] w,
                             input logic [31:0] d);
    logic [9:0] idx;
    idx = a[11:2];
    if (!exp_err(a, w)) begin
      for (int i = 0; i < 4; i++) begin
        if (w[i]) ref_mem[k][idx][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  function automatic logic [31:0] exp_load(input int k, input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    return exp_err(a, 4'b0000) ? 32'd0 : ref_mem[k][idx];
  endfunction

  // ---------------- driver ----------------
  // Issues one request to instance k, returns response latency (edges after
  // accept) and captured response, or lat=-1 when no response arrives.
  task automatic send(input int k, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, output int lat,
                      output logic [31:0] rd, output logic er);
    int guard;
    lat = -1; rd = 32'd0; er = 1'b0;
    sel = k;
    @(negedge clk);
    addr = a; we = w; wdata = d; vld[k] = 1'b1;
    guard = 0;
    while (!o_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout inst=%0d got ready=%0b want 1", k, o_ready);
      vld[k] = 1'b0;
      return;
    end
    @(posedge clk);
    if (w != 4'b0000) model_store(k, a, w, d);
    #1 vld[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 40);
    if (o_valid) begin
      rd = o_rdata;
      er = o_err;
    end else begin
      lat = -1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0; vld = 3'b000; addr = '0; we = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      n_cmp++;
      if ({o_ready, o_valid, o_err, o_rdata} !== 35'd0) begin
        n_bad++;
        $display("FAIL reset_outputs inst=%0d got rdy=%0b vld=%0b err=%0b rdata=%h want all 0",
                 k, o_ready, o_valid, o_err, o_rdata);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [31:0] rd; logic er;
    send(1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, rd, er);
    n_cmp++;
    if (lat !== 1 || rd !== 32'd0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_store got lat=%0d rdata=%h err=%0b want lat=1 rdata=0 err=0", lat, rd, er);
    end
    send(1, 32'h10, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_load got lat=%0d rdata=%h err=%0b want lat=2 rdata=deadbeef err=0", lat, rd, er);
    end
  endtask

  task automatic test_byte_merge;
    int lat; logic [31:0] rd; logic er;
    send(1, 32'h20, 4'b1111, 32'h11223344, lat, rd, er);
    send(1, 32'h20, 4'b0010, 32'h0000AA00, lat, rd, er);
    send(1, 32'h22, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h1122AA44) begin
      n_bad++;
      $display("FAIL byte_merge got lat=%0d rdata=%h want lat=2 rdata=1122aa44", lat, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    d = $urandom;
    sel = 0;
    @(negedge clk);
    addr = 32'h30; we = 4'b1111; wdata = d; vld[0] = 1'b1;
    @(posedge clk);
    model_store(0, 32'h30, 4'b1111, d);
    #1 we = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL b2b_store_rsp got vld=%0b rdata=%h want vld=1 rdata=0", o_valid, o_rdata);
    end
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_rdata !== d) begin
      n_bad++;
      $display("FAIL b2b_load_rsp got vld=%0b rdata=%h want vld=1 rdata=%h", o_valid, o_rdata, d);
    end
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_pulse_end got vld=%0b want 0", o_valid);
    end
  endtask

  task automatic test_reset_mid_wait;
    int lat; int pulses; logic [31:0] rd; logic er; logic [31:0] d;
    d = $urandom;
    send(2, 32'h40, 4'b1111, d, lat, rd, er);
    sel = 2;
    @(negedge clk);
    addr = 32'h40; we = 4'b0000; vld[2] = 1'b1;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_not_ready got ready=%0b want 0", o_ready);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_drops_load got pulses=%0d want 0", pulses);
    end
    send(2, 32'h40, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (lat !== 4 || rd !== d) begin
      n_bad++;
      $display("FAIL load_after_reset got lat=%0d rdata=%h want lat=4 rdata=%h", lat, rd, d);
    end
  endtask

  task automatic test_reset_after_store;
    int lat; logic [31:0] rd; logic er; logic [31:0] d;
    d = $urandom;
    sel = 1;
    @(negedge clk);
    addr = 32'h50; we = 4'b1111; wdata = d; vld[1] = 1'b1;
    @(posedge clk);
    model_store(1, 32'h50, 4'b1111, d);
    #1 vld[1] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(1, 32'h50, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== d) begin
      n_bad++;
      $display("FAIL store_survives_reset got lat=%0d rdata=%h want lat=2 rdata=%h", lat, rd, d);
    end
  endtask

  task automatic test_addr_range;
    int lat; logic [31:0] rd; logic er;
`ifdef DMEM_ERRCHK_EN
    send(1, 32'h0, 4'b1111, 32'h01020304, lat, rd, er);
    send(1, 32'h00001000, 4'b1111, 32'hCAFEF00D, lat, rd, er);
    n_cmp++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
      n_bad++;
      $display("FAIL err_high_addr got lat=%0d err=%0b rdata=%h want lat=1 err=1 rdata=0", lat, er, rd);
    end
    send(1, 32'h0, 4'b0101, 32'hFFFFFFFF, lat, rd, er);
    n_cmp++;
    if (lat !== 1 || er !== 1'b1) begin
      n_bad++;
      $display("FAIL err_bad_we got lat=%0d err=%0b want lat=1 err=1", lat, er);
    end
    send(1, 32'h0, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL err_no_write got rdata=%h err=%0b want rdata=01020304 err=0", rd, er);
    end
    send(1, 32'h00001000, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin
      n_bad++;
      $display("FAIL err_load got lat=%0d err=%0b rdata=%h want lat=2 err=1 rdata=0", lat, er, rd);
    end
`else
    send(1, 32'h00001000, 4'b1111, 32'hCAFEF00D, lat, rd, er);
    send(1, 32'h0, 4'b0000, 32'd0, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
      n_bad++;
      $display("FAIL addr_wrap got lat=%0d rdata=%h err=%0b want lat=2 rdata=cafef00d err=0", lat, rd, er);
    end
`endif
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd; logic er;
    logic [31:0] a, d, exp_rd;
    logic [3:0] w;
    int exp_lat;
    logic exp_e;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        send(k, 32'(i * 4), 4'b1111, d, lat, rd, er);
        n_cmp++;
        if (lat !== 1 || rd !== 32'd0 || er !== 1'b0) begin
          n_bad++;
          $display("FAIL prefill inst=%0d word=%0d got lat=%0d rdata=%h err=%0b want lat=1 rdata=0 err=0",
                   k, i, lat, rd, er);
        end
      end
      for (int n = 0; n < 40; n++) begin
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
`ifdef DMEM_ERRCHK_EN
        if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
`endif
        w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        d = $urandom;
        exp_e = exp_err(a, w);
        exp_lat = (w != 4'b0000) ? 1 : wait_of(k) + 1;
        exp_rd = (w != 4'b0000) ? 32'd0 : exp_load(k, a);
        send(k, a, w, d, lat, rd, er);
        n_cmp++;
        if (lat !== exp_lat || rd !== exp_rd || er !== exp_e) begin
          n_bad++;
          $display("FAIL random inst=%0d addr=%h we=%b got lat=%0d rdata=%h err=%0b want lat=%0d rdata=%h err=%0b",
                   k, a, w, lat, rd, er, exp_lat, exp_rd, exp_e);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    sel = 0;
    test_reset();
    test_basic();
    test_byte_merge();
    test_back_to_back();
    test_reset_mid_wait();
    test_reset_after_store();
    test_addr_range();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
